// File: rtl/axib_pkg.sv
// Shared AXI encodings and helpers for the AXI4-Lite to AXI4 bridge.
package axib_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_PROT_NS    = 3'b010;
  localparam logic [2:0] AXI_PROT_INSN  = 3'b100;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic logic [2:0] axsize(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axib_skid.sv
// Two-entry register slice; ready is registered from the next occupancy so no
// combinational path exists between the two sides.
module axib_skid #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   count_nxt;
  logic         push;
  logic         pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/axilite_axi4_bridge.sv
// AXI4-Lite slave to single-beat AXI4 master bridge with per-direction
// outstanding limits. Optional saturating error counter under AXIB_ERRCNT_EN.
module axilite_axi4_bridge
  import axib_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int INSN_PORT = 0,
  parameter int PROT_NS   = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic [2:0]          m_arprot,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready
`ifdef AXIB_ERRCNT_EN
  ,
  output logic [15:0]         err_cnt
`endif
);

  localparam int         SW    = DATA_W / 8;
  localparam logic [3:0] MAX_O = 4'(MAX_OUTST);

  logic [3:0]           wr_out;
  logic [3:0]           rd_out;
  logic                 aw_v, ar_v;
  logic                 aw_gate, ar_gate;
  logic                 aw_hs, ar_hs, b_hs, r_hs;
  logic [DATA_W+SW-1:0] w_q;
  logic [DATA_W+1:0]    r_q;

  assign m_awlen   = 8'd0;
  assign m_arlen   = 8'd0;
  assign m_awburst = AXI_BURST_INCR;
  assign m_arburst = AXI_BURST_INCR;
  assign m_awsize  = axsize(DATA_W);
  assign m_arsize  = axsize(DATA_W);
  assign m_wlast   = 1'b1;
  assign m_awprot  = (PROT_NS != 0) ? AXI_PROT_NS : 3'b000;
  assign m_arprot  = ((PROT_NS != 0) ? AXI_PROT_NS : 3'b000)
                   | ((INSN_PORT != 0) ? AXI_PROT_INSN : 3'b000);

  // Address channels stall in their buffer while the direction is at its limit.
  assign aw_gate   = (wr_out != MAX_O);
  assign ar_gate   = (rd_out != MAX_O);
  assign m_awvalid = aw_v & aw_gate;
  assign m_arvalid = ar_v & ar_gate;
  assign aw_hs     = m_awvalid & m_awready;
  assign ar_hs     = m_arvalid & m_arready;
  assign b_hs      = m_bvalid & m_bready;
  assign r_hs      = m_rvalid & m_rready;

  assign m_wdata = w_q[DATA_W+SW-1:SW];
  assign m_wstrb = w_q[SW-1:0];
  assign s_rdata = r_q[DATA_W+1:2];
  assign s_rresp = r_q[1:0];

  axib_skid #(.W(ADDR_W)) u_aw (
    .aclk(aclk), .aresetn(aresetn),
    .in_data(s_awaddr), .in_valid(s_awvalid), .in_ready(s_awready),
    .out_data(m_awaddr), .out_valid(aw_v), .out_ready(m_awready & aw_gate)
  );

  axib_skid #(.W(DATA_W+SW)) u_w (
    .aclk(aclk), .aresetn(aresetn),
    .in_data({s_wdata, s_wstrb}), .in_valid(s_wvalid), .in_ready(s_wready),
    .out_data(w_q), .out_valid(m_wvalid), .out_ready(m_wready)
  );

  axib_skid #(.W(ADDR_W)) u_ar (
    .aclk(aclk), .aresetn(aresetn),
    .in_data(s_araddr), .in_valid(s_arvalid), .in_ready(s_arready),
    .out_data(m_araddr), .out_valid(ar_v), .out_ready(m_arready & ar_gate)
  );

  axib_skid #(.W(2)) u_b (
    .aclk(aclk), .aresetn(aresetn),
    .in_data(m_bresp), .in_valid(m_bvalid), .in_ready(m_bready),
    .out_data(s_bresp), .out_valid(s_bvalid), .out_ready(s_bready)
  );

  axib_skid #(.W(DATA_W+2)) u_r (
    .aclk(aclk), .aresetn(aresetn),
    .in_data({m_rdata, m_rresp}), .in_valid(m_rvalid), .in_ready(m_rready),
    .out_data(r_q), .out_valid(s_rvalid), .out_ready(s_rready)
  );

  // A response with nothing outstanding is forwarded but leaves the count at 0.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_out <= 4'd0;
      rd_out <= 4'd0;
    end else begin
      if (aw_hs && !b_hs)
        wr_out <= wr_out + 4'd1;
      else if (b_hs && !aw_hs && wr_out != 4'd0)
        wr_out <= wr_out - 4'd1;
      if (ar_hs && !r_hs)
        rd_out <= rd_out + 4'd1;
      else if (r_hs && !ar_hs && rd_out != 4'd0)
        rd_out <= rd_out - 4'd1;
    end
  end

`ifdef AXIB_ERRCNT_EN
  logic        b_err;
  logic        r_err;
  logic [16:0] err_sum;

  assign b_err   = b_hs && ((m_bresp != AXI_RESP_OKAY) || (wr_out == 4'd0));
  assign r_err   = r_hs && ((m_rresp != AXI_RESP_OKAY) || !m_rlast || (rd_out == 4'd0));
  assign err_sum = {1'b0, err_cnt} + {16'd0, b_err} + {16'd0, r_err};

  always_ff @(posedge aclk) begin
    if (!aresetn)
      err_cnt <= 16'd0;
    else
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end
`else
  logic rlast_unused;
  assign rlast_unused = m_rlast;
`endif

endmodule

// File: tb/tb_axilite_axi4_bridge.sv
// Directed bench for axilite_axi4_bridge: constants, latency, outstanding
// limits, backpressure, response pass-through, errors and mid-run reset.
module tb_axilite_axi4_bridge;
  import axib_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata, m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [3:0]  s_wstrb, m_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp, m_bresp, m_rresp, m_awburst, m_arburst;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_arsize, m_awprot, m_arprot;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [15:0] err_cnt;

  logic [31:0] x_awaddr, x_araddr;
  logic [63:0] x_srdata, x_wdata;
  logic [7:0]  x_wstrb, x_awlen, x_arlen;
  logic [1:0]  x_bresp, x_rresp, x_awburst, x_arburst;
  logic [2:0]  x_awsize, x_arsize, x_awprot, x_arprot;
  logic        x_awready, x_wready, x_bvalid, x_arready, x_rvalid;
  logic        x_awvalid, x_wlast, x_wvalid, x_bready, x_arvalid, x_rready;
  logic [15:0] x_err_cnt;

  int checks = 0;
  int failures = 0;
  int ar_hs_cnt = 0;
  logic [3:0] max_rd = 4'd0;

  always #5 aclk = ~aclk;

  axilite_axi4_bridge #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .INSN_PORT(0), .PROT_NS(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
`ifdef AXIB_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  axilite_axi4_bridge #(.ADDR_W(32), .DATA_W(64), .MAX_OUTST(4), .INSN_PORT(1), .PROT_NS(1)) dut64 (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr('0), .s_awvalid(1'b0), .s_awready(x_awready),
    .s_wdata('0), .s_wstrb('0), .s_wvalid(1'b0), .s_wready(x_wready),
    .s_bresp(x_bresp), .s_bvalid(x_bvalid), .s_bready(1'b1),
    .s_araddr('0), .s_arvalid(1'b0), .s_arready(x_arready),
    .s_rdata(x_srdata), .s_rresp(x_rresp), .s_rvalid(x_rvalid), .s_rready(1'b1),
    .m_awaddr(x_awaddr), .m_awlen(x_awlen), .m_awsize(x_awsize), .m_awburst(x_awburst),
    .m_awprot(x_awprot), .m_awvalid(x_awvalid), .m_awready(1'b1),
    .m_wdata(x_wdata), .m_wstrb(x_wstrb), .m_wlast(x_wlast), .m_wvalid(x_wvalid), .m_wready(1'b1),
    .m_bresp(2'b00), .m_bvalid(1'b0), .m_bready(x_bready),
    .m_araddr(x_araddr), .m_arlen(x_arlen), .m_arsize(x_arsize), .m_arburst(x_arburst),
    .m_arprot(x_arprot), .m_arvalid(x_arvalid), .m_arready(1'b1),
    .m_rdata('0), .m_rresp(2'b00), .m_rlast(1'b1), .m_rvalid(1'b0), .m_rready(x_rready)
`ifdef AXIB_ERRCNT_EN
    , .err_cnt(x_err_cnt)
`endif
  );

  always @(posedge aclk) begin
    if (aresetn === 1'b1 && m_arvalid && m_arready) ar_hs_cnt <= ar_hs_cnt + 1;
    if (dut.rd_out > max_rd) max_rd <= dut.rd_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int issued;
    int ar_base;
    logic hs;

    aresetn = 1'b0;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 1;
    s_araddr = '0; s_arvalid = 0; s_rready = 1;
    m_awready = 1; m_wready = 1; m_arready = 1;
    m_bresp = 2'b00; m_bvalid = 0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1; m_rvalid = 0;
    tick(); tick();

    chk("rst_readies", {s_awready, s_wready, s_arready, m_bready, m_rready}, 5'b00000);
    chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}, 5'b00000);
    chk("rst_counters", {dut.wr_out, dut.rd_out}, 8'h00);
    chk("x64_arsize", x_arsize, 3'd3);
    chk("x64_awsize", x_awsize, 3'd3);
    chk("x64_arprot", x_arprot, 3'b110);
    chk("x64_awprot", x_awprot, 3'b010);

    aresetn = 1'b1;
    tick();
    chk("readies_up", {s_awready, s_wready, s_arready, m_bready, m_rready}, 5'b11111);

    // single write
    s_awaddr = 32'h1000; s_awvalid = 1; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    chk("aw_valid_n1", m_awvalid, 1'b1);
    chk("aw_addr", m_awaddr, 32'h1000);
    chk("aw_consts", {m_awlen, m_awsize, m_awburst, m_awprot}, {8'd0, 3'd2, 2'b01, 3'b010});
    chk("w_beat", {m_wvalid, m_wlast, m_wdata, m_wstrb}, {1'b1, 1'b1, 32'hDEADBEEF, 4'hF});
    tick();
    chk("aw_drained", m_awvalid, 1'b0);
    chk("wr_out_1", dut.wr_out, 4'd1);
    m_bvalid = 1; m_bresp = 2'b00;
    tick();
    m_bvalid = 0;
    chk("b_return", {s_bvalid, s_bresp}, {1'b1, 2'b00});
    chk("wr_out_0", dut.wr_out, 4'd0);
    tick();

    // outstanding read limit
    ar_base = ar_hs_cnt;
    issued = 0;
    s_araddr = 32'h2000; s_arvalid = 1;
    for (int c = 0; c < 20 && issued < 6; c++) begin
      hs = s_arready;
      tick();
      if (hs) begin
        issued++;
        s_araddr = s_araddr + 32'd4;
        if (issued == 6) s_arvalid = 0;
      end
    end
    s_arvalid = 0;
    chk("reads_accepted", issued, 6);
    tick(); tick(); tick();
    chk("ar_hs_limit", ar_hs_cnt - ar_base, 4);
    chk("rd_out_max", dut.rd_out, 4'd4);
    chk("ar_masked", {m_arvalid, s_arready}, 2'b00);
    m_rvalid = 1; m_rdata = 32'h000000A0; m_rresp = 2'b00;
    tick();
    m_rvalid = 0;
    chk("r_first", {s_rvalid, s_rdata}, {1'b1, 32'h000000A0});
    chk("ar5_valid", {m_arvalid, m_araddr}, {1'b1, 32'h00002010});
    tick();
    chk("ar_hs_5", ar_hs_cnt - ar_base, 5);
    chk("rd_out_4b", dut.rd_out, 4'd4);

    // simultaneous issue and retire
    m_arready = 0;
    m_rvalid = 1; m_rdata = 32'hB1;
    tick();
    m_rdata = 32'hB2;
    tick();
    chk("rd_out_2", dut.rd_out, 4'd2);
    chk("ar6_pending", m_arvalid, 1'b1);
    m_arready = 1; m_rdata = 32'hB3;
    tick();
    m_rvalid = 0;
    chk("rd_out_same", dut.rd_out, 4'd2);
    chk("ar_hs_6", ar_hs_cnt - ar_base, 6);
    chk("rd_max_seen", max_rd, 4'd4);
    tick();

    s_araddr = 32'h3000; s_arvalid = 1;
    tick();
    s_arvalid = 0;
    chk("ar7", {m_arvalid, m_araddr}, {1'b1, 32'h3000});
    chk("ar_consts", {m_arlen, m_arsize, m_arburst, m_arprot}, {8'd0, 3'd2, 2'b01, 3'b010});
    tick();
    chk("rd_out_3", dut.rd_out, 4'd3);

    // R backpressure
    s_rready = 0;
    m_rvalid = 1; m_rdata = 32'hC1;
    tick();
    m_rdata = 32'hC2;
    tick();
    m_rdata = 32'hC3;
    chk("r_full_ready", m_rready, 1'b0);
    tick();
    chk("r_hold", {m_rready, s_rvalid, s_rdata}, {1'b0, 1'b1, 32'hC1});
    chk("rd_out_1", dut.rd_out, 4'd1);
    s_rready = 1;
    tick();
    chk("r_order2", {m_rready, s_rdata}, {1'b1, 32'hC2});
    tick();
    m_rvalid = 0;
    chk("r_order3", {s_rvalid, s_rdata}, {1'b1, 32'hC3});
    tick();
    chk("r_empty", {s_rvalid, dut.rd_out}, {1'b0, 4'd0});

    // response pass-through and error counting
    s_awaddr = 32'h4000; s_awvalid = 1; s_araddr = 32'h5000; s_arvalid = 1;
    tick();
    s_awvalid = 0; s_arvalid = 0;
    tick();
    chk("err_setup", {dut.wr_out, dut.rd_out}, 8'h11);
`ifdef AXIB_ERRCNT_EN
    chk("err_cnt_0", err_cnt, 16'd0);
`endif
    m_bvalid = 1; m_bresp = AXI_RESP_DECERR;
    m_rvalid = 1; m_rresp = AXI_RESP_SLVERR; m_rdata = 32'hE0; m_rlast = 1;
    tick();
    m_bvalid = 0; m_rvalid = 0; m_rresp = 2'b00; m_bresp = 2'b00;
    chk("b_decerr", {s_bvalid, s_bresp}, {1'b1, 2'b11});
    chk("r_slverr", {s_rvalid, s_rresp, s_rdata}, {1'b1, 2'b10, 32'hE0});
    chk("err_retired", {dut.wr_out, dut.rd_out}, 8'h00);
`ifdef AXIB_ERRCNT_EN
    chk("err_cnt_2", err_cnt, 16'd2);
`endif
    tick();

    // reset with reads outstanding
    s_arvalid = 1; s_araddr = 32'h6000;
    tick();
    s_araddr = 32'h6004;
    tick();
    s_araddr = 32'h6008;
    tick();
    s_arvalid = 0;
    tick(); tick();
    chk("pre_rst_rd", dut.rd_out, 4'd3);
    aresetn = 1'b0;
    tick();
    chk("mid_rst_readies", {s_awready, s_wready, s_arready, m_bready, m_rready}, 5'b00000);
    chk("mid_rst_valids", {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}, 5'b00000);
    chk("mid_rst_cnt", {dut.wr_out, dut.rd_out}, 8'h00);
`ifdef AXIB_ERRCNT_EN
    chk("mid_rst_err", err_cnt, 16'd0);
`endif
    aresetn = 1'b1;
    tick();
    chk("post_rst_readies", {s_awready, s_wready, s_arready, m_bready, m_rready}, 5'b11111);
    s_araddr = 32'h7000; s_arvalid = 1;
    tick();
    s_arvalid = 0;
    chk("post_rst_ar", {m_arvalid, m_araddr}, {1'b1, 32'h7000});
    tick();
    chk("post_rst_rd", dut.rd_out, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axilite_axi4_bridge.md
# axilite_axi4_bridge

Parametrised AXI4-Lite slave to AXI4 (full) master bridge. It sits between an rvee core master port and a full-AXI slave port of the block design. It replaces hand-written per-port tie-offs of size/len/burst/last/prot with generated single-beat AXI4 signalling. It adds registered channels and per-direction outstanding-transaction limiting, which the plain wire-through connection lacks.

## Interface
Parameters:
- ADDR_W, 32: address width, both sides.
- DATA_W, 32: data width, 32 or 64 only.
- MAX_OUTST, 4: maximum outstanding transactions per direction, 1..15.
- INSN_PORT, 0: 1 sets AXI_PROT_INSN on m_arprot; used for instruction-fetch ports.
- PROT_NS, 1: 1 sets AXI_PROT_NS on m_arprot and m_awprot.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset; synchronous, active-low.
- s_aw*/s_w*/s_b*/s_ar*/s_r*  AXI-Lite slave: awaddr[ADDR_W], awvalid/awready, wdata[DATA_W], wstrb[DATA_W/8], wvalid/wready, bresp[2], bvalid/bready, araddr[ADDR_W], arvalid/arready, rdata[DATA_W], rresp[2], rvalid/rready.
- m_aw*/m_w*/m_b*/m_ar*/m_r*  AXI4 master: Lite signals plus awlen[8], awsize[3], awburst[2], awprot[3], wlast, arlen[8], arsize[3], arburst[2], arprot[3], rlast.
- err_cnt  out  16  saturating error count; present only with AXIB_ERRCNT_EN.

## Operation
- Each of the five channels passes through a 2-entry skid buffer. Forward channels are AW, W and AR; return channels are B and R. All outputs are registered and there is no combinational valid-to-ready path.
- Constant fields:
  - m_awlen = m_arlen = 0.
  - m_awburst = m_arburst = AXI_BURST_INCR.
  - m_awsize = m_arsize = log2(DATA_W/8), i.e. 2 for 32-bit and 3 for 64-bit.
  - m_wlast = 1 whenever m_wvalid.
  - m_arprot = (PROT_NS ? AXI_PROT_NS : 0) | (INSN_PORT ? AXI_PROT_INSN : 0).
  - m_awprot = PROT_NS ? AXI_PROT_NS : 0.
- Outstanding write counter wr_out (4 bits):
  - +1 on an m_aw handshake.
  - −1 on an m_b handshake.
  - Unchanged when both occur in the same cycle.
  - m_awvalid is masked, and the AW buffer holds its entry, while wr_out == MAX_OUTST.
- Outstanding read counter rd_out behaves the same way, using m_ar and m_r handshakes.
- Counter boundaries:
  - Neither counter can exceed MAX_OUTST or go below 0.
  - A response arriving while the counter is 0 is a protocol error. It is forwarded anyway, the counter stays 0, and (with AXIB_ERRCNT_EN) it counts as an error.
- m_rlast is ignored for flow control. m_rvalid with m_rlast = 0 counts as an error under AXIB_ERRCNT_EN.
- AW and W are independent. W may precede AW on both sides, and only AW is gated by wr_out.
- bresp and rresp pass through unmodified.

## Timing
- Reset (aresetn = 0 at a clock edge):
  - All skid buffers empty, counters 0, err_cnt 0.
  - Every valid output is 0 and every ready output is 0.
- Ready outputs go to 1 on the first cycle after aresetn is sampled high.
- Forward latency: an s_awvalid handshake in cycle N gives m_awvalid = 1 in cycle N+1. The same applies to W and AR.
- Return latency: m_bvalid/m_rvalid handshake in cycle N gives s_bvalid/s_rvalid in cycle N+1.
- Throughput: one transfer per cycle per channel with no backpressure. A buffer accepts 2 beats before deasserting ready.
- Ready derivation: s_*ready = !buffer_full, registered. It deasserts in the cycle after the second entry fills.
- Reset mid-transaction: in-flight transfers are discarded and counters are cleared. The system resets both sides together, and no recovery is attempted.

## Configuration
- AXIB_ERRCNT_EN defined:
  - err_cnt port exists.
  - It increments by 1 per m_b handshake with bresp ≠ OKAY, per m_r handshake with rresp ≠ OKAY or rlast = 0, and per response arriving with its counter at 0.
  - It saturates at 16'hFFFF. Simultaneous B and R errors in one cycle add 2, still saturating.
- AXIB_ERRCNT_EN undefined: no err_cnt port and no counter logic. Responses are still forwarded identically.

## Structure
- Package axib_pkg holds:
  - AXI_BURST_INCR, AXI_PROT_NS, AXI_PROT_INSN and response codes (OKAY, SLVERR, DECERR).
  - A constant function axsize(DATA_W) returning the 3-bit size.
- Sub-module axib_skid: parameter W, 2-entry register slice with valid/ready on both sides. It is instantiated five times, and the payload width differs per channel.
- The top module holds the two counters, the AW/AR gating, constant field generation and the optional error counter.

## Test plan
- Single write: s_awaddr=0x1000, wdata=0xDEADBEEF, wstrb=0xF, slave replies OKAY. Expect m_awvalid in cycle N+1 with awlen=0, awsize=2, awburst=INCR, awprot=NS, wlast=1; s_bresp=OKAY one cycle after m_b.
- Outstanding limit: MAX_OUTST=4, slave withholds AR responses, issue 6 reads. Exactly 4 m_ar handshakes occur. After one m_r beat the fifth read issues; rd_out never exceeds 4.
- Simultaneous issue/retire: rd_out=2, m_ar and m_r handshakes in the same cycle. rd_out stays 2.
- Backpressure: s_rready=0 and 3 reads returned. The R buffer holds 2, m_rready deasserts, data order is preserved on release.
- Config/error: DATA_W=64, INSN_PORT=1, AXIB_ERRCNT_EN defined; one read returns SLVERR and one B returns DECERR in the same cycle. Expect arsize=3, arprot=NS|INSN, err_cnt 0→2.
- Mid-operation reset: aresetn low for 1 cycle with 3 reads outstanding. All valids and readies are 0, counters 0; traffic resumes with readies high on the next cycle.
